// File: rtl/avr_io_bridge.sv
// avr_io_bridge: host-stream to AVR IO-bus initiator.
// Takes read/write command bytes from a host byte stream, wins the IO bus
// through a bus_req/bus_gnt handshake, performs one strobe per transfer and
// returns read data on a byte-wide response stream.
// Optional burst support is compiled in with `define AVR_IO_BRIDGE_BURST_EN.
//
// Handshakes: a byte moves on rx (resp. tx) at a rising edge where
// valid & ready are both high; a raised valid is held with stable data until
// that edge; ready may change freely and never waits on valid.
module avr_io_bridge (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       bus_req,
  input  logic       bus_gnt,
  output logic [5:0] io_addr,
  inout  wire  [7:0] io_data,
  output logic       io_read,
  output logic       io_write
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_LEN  = 3'd1,
    S_GET_DATA = 3'd2,
    S_REQ      = 3'd3,
    S_XFER     = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       wr_q, wr_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       own_bus;
  logic       last_beat;
  logic       cmd_burst;

`ifdef AVR_IO_BRIDGE_BURST_EN
  // Remaining transfers after the current one.
  logic [7:0] cnt_q, cnt_d;
  assign cmd_burst = rx_data[6];
  assign last_beat = (cnt_q == 8'd0);
`else
  logic unused_burst_bit;
  assign unused_burst_bit = rx_data[6];
  assign cmd_burst = 1'b0;
  assign last_beat = 1'b1;
`endif

  // The bridge owns the bus only while granted in the transfer state.
  assign own_bus  = (state_q == S_XFER) && bus_gnt;

  assign rx_ready = (state_q == S_IDLE) || (state_q == S_GET_LEN) ||
                    (state_q == S_GET_DATA);
  assign tx_valid = (state_q == S_RESP);
  assign tx_data  = rdata_q;
  assign bus_req  = (state_q == S_REQ) || (state_q == S_XFER);

  assign io_addr  = own_bus ? addr_q : 6'bzzzzzz;
  assign io_read  = own_bus ? ~wr_q : 1'bz;
  assign io_write = own_bus ? wr_q : 1'bz;
  assign io_data  = (own_bus && wr_q) ? wdata_q : 8'hzz;

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 6'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
`ifdef AVR_IO_BRIDGE_BURST_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef AVR_IO_BRIDGE_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef AVR_IO_BRIDGE_BURST_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          wr_d   = rx_data[7];
          addr_d = rx_data[5:0];
`ifdef AVR_IO_BRIDGE_BURST_EN
          cnt_d  = 8'd0;
`endif
          if (cmd_burst)       state_d = S_GET_LEN;
          else if (rx_data[7]) state_d = S_GET_DATA;
          else                 state_d = S_REQ;
        end
      end
      S_GET_LEN: begin
        if (rx_valid) begin
`ifdef AVR_IO_BRIDGE_BURST_EN
          cnt_d = rx_data;
`endif
          state_d = wr_q ? S_GET_DATA : S_REQ;
        end
      end
      S_GET_DATA: begin
        if (rx_valid) begin
          wdata_d = rx_data;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus_gnt) state_d = S_XFER;
      end
      S_XFER: begin
        if (bus_gnt) begin
`ifdef AVR_IO_BRIDGE_BURST_EN
          addr_d = addr_q + 6'd1;
`endif
          if (!wr_q) begin
            rdata_d = io_data;
            state_d = S_RESP;
          end else if (last_beat) begin
            state_d = S_IDLE;
          end else begin
`ifdef AVR_IO_BRIDGE_BURST_EN
            cnt_d = cnt_q - 8'd1;
`endif
            state_d = S_GET_DATA;
          end
        end else begin
          // Grant lost before the strobe: release and request again.
          state_d = S_REQ;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
`ifdef AVR_IO_BRIDGE_BURST_EN
            cnt_d = cnt_q - 8'd1;
`endif
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_avr_io_bridge.sv
// Bench for avr_io_bridge: directed protocol scenarios plus randomized
// command traffic, checked every cycle against an expected-operation model.
module tb_avr_io_bridge;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  wire        rx_ready;
  wire  [7:0] tx_data;
  wire        tx_valid;
  logic       tx_ready = 1'b1;
  wire        bus_req;
  logic       bus_gnt  = 1'b0;
  wire  [5:0] io_addr;
  wire  [7:0] io_data;
  wire        io_read;
  wire        io_write;

  logic [7:0] resp_val = 8'h00;

  avr_io_bridge dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .io_addr  (io_addr),
    .io_data  (io_data),
    .io_read  (io_read),
    .io_write (io_write)
  );

  // Bus responder: returns resp_val combinationally during a read strobe.
  assign io_data = (io_read == 1'b1 && bus_gnt) ? resp_val : 8'hzz;

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  logic [14:0] exp_bus_q[$];   // {is_write, addr, write_data or 0}
  logic [7:0]  exp_tx_q[$];
  logic [5:0]  addr_log[$];
  bit gnt_rand = 1'b0;
  bit tx_rand = 1'b0;
  bit resp_rand = 1'b0;
  int max_gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Randomized environment: grant, response acceptance, read data.
  always @(posedge clk) begin
    #1;
    if (gnt_rand)  bus_gnt  = ($urandom_range(0, 3) != 0);
    if (tx_rand)   tx_ready = $urandom_range(0, 1);
    if (resp_rand) resp_val = 8'($urandom);
  end

  // Per-cycle compare against the expected bus operations and responses.
  always @(negedge clk) begin
    logic [14:0] act;
    logic        is_wr;
    if (!rst) begin
      if (io_write === 1'b1 || io_read === 1'b1) begin
        strobe_cnt++;
        is_wr = (io_write === 1'b1);
        chk("strobe_owned", {bus_req, bus_gnt, (io_read === 1'b1) && is_wr}, 3'b110);
        act = {is_wr, io_addr, is_wr ? io_data : 8'h00};
        addr_log.push_back(io_addr);
        if (exp_bus_q.size() == 0) fail_now("bus_unexpected_strobe");
        else chk("bus_op", act, exp_bus_q.pop_front());
        if (!is_wr) exp_tx_q.push_back(resp_val);
      end
      if (tx_valid === 1'b1) begin
        chk("resp_excl", {bus_req, rx_ready}, 2'b00);
        if (exp_tx_q.size() == 0) fail_now("tx_unexpected");
        else begin
          chk("tx_data", tx_data, exp_tx_q[0]);
          if (tx_ready) void'(exp_tx_q.pop_front());
        end
      end
      if (bus_req === 1'b1) chk("req_rx_ready", rx_ready, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int gap;
    int k;
    bit ok;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (k = 0; k < 5000 && !ok; k++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) fail_now("rx_accept_timeout");
    rx_valid = 1'b0;
  endtask

  // Issue one command; the model derives every bus operation it implies.
  task automatic do_cmd(input bit wr, input bit burst, input logic [5:0] addr,
                        input int len, input logic [7:0] first_data);
    int beats;
    logic [7:0] d[$];
    logic [5:0] a;
`ifdef AVR_IO_BRIDGE_BURST_EN
    beats = burst ? len + 1 : 1;
`else
    beats = 1;
`endif
    for (int i = 0; i < beats; i++) begin
      d.push_back((i == 0) ? first_data : 8'($urandom));
      a = 6'((int'(addr) + i) % 64);
      exp_bus_q.push_back({wr, a, wr ? d[i] : 8'h00});
    end
    send_byte({wr, burst, addr});
`ifdef AVR_IO_BRIDGE_BURST_EN
    if (burst) send_byte(8'(len));
`endif
    if (wr) begin
      for (int i = 0; i < beats; i++) send_byte(d[i]);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (k < 4000 && !(exp_bus_q.size() == 0 && exp_tx_q.size() == 0 &&
                         rx_ready === 1'b1 && bus_req === 1'b0 && tx_valid === 1'b0)) begin
      @(negedge clk);
      k++;
    end
    if (k >= 4000) fail_now("idle_timeout");
    @(posedge clk);
    #1;
  endtask

  // Watchdog.
  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int s0;
    logic [5:0] exp_addrs[$];

    // Reset values.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rx_ready", rx_ready, 1'b1);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_strobes", {io_read === 1'b1, io_write === 1'b1}, 2'b00);
    @(posedge clk);
    #1;

    // Single write 0x96, 0x3C with grant high.
    bus_gnt = 1'b1;
    s0 = strobe_cnt;
    do_cmd(1'b1, 1'b0, 6'h16, 0, 8'h3C);
    @(negedge clk);
    chk("wr_c1_req", {bus_req, io_write === 1'b1}, 2'b10);
    @(negedge clk);
    chk("wr_c2_strobe", {io_write === 1'b1, io_addr, io_data}, {1'b1, 6'h16, 8'h3C});
    @(negedge clk);
    chk("wr_c3_ready", {rx_ready, bus_req, tx_valid}, 3'b100);
    wait_idle();
    chk("wr_one_strobe", strobe_cnt - s0, 1);

    // Single read of 0x16, responder returns 0xA5.
    resp_val = 8'hA5;
    s0 = strobe_cnt;
    do_cmd(1'b0, 1'b0, 6'h16, 0, 8'h00);
    @(negedge clk);
    chk("rd_c1", {bus_req, tx_valid}, 2'b10);
    @(negedge clk);
    chk("rd_c2_strobe", {io_read === 1'b1, io_addr}, {1'b1, 6'h16});
    @(negedge clk);
    chk("rd_c3_resp", {tx_valid, tx_data}, {1'b1, 8'hA5});
    @(negedge clk);
    chk("rd_c4_done", tx_valid, 1'b0);
    wait_idle();
    chk("rd_one_strobe", strobe_cnt - s0, 1);

    // Grant withheld 10 cycles, dropped once in XFER; response stalled 5 cycles.
    bus_gnt  = 1'b0;
    tx_ready = 1'b0;
    resp_val = 8'h5A;
    s0 = strobe_cnt;
    do_cmd(1'b0, 1'b0, 6'h05, 0, 8'h00);
    repeat (10) begin
      @(negedge clk);
      chk("wait_gnt", {bus_req, io_read === 1'b1}, 2'b10);
    end
    @(posedge clk);
    #1 bus_gnt = 1'b1;
    @(posedge clk);
    #1 bus_gnt = 1'b0;
    @(negedge clk);
    chk("gnt_drop_no_strobe", {bus_req, io_read === 1'b1}, 2'b10);
    @(posedge clk);
    #1 bus_gnt = 1'b1;
    repeat (3) @(negedge clk);
    chk("retry_one_strobe", strobe_cnt - s0, 1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_resp", {tx_valid, tx_data, rx_ready, bus_req}, {1'b1, 8'h5A, 1'b0, 1'b0});
    end
    chk("stall_no_bus", strobe_cnt - s0, 1);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_idle();

    // Command 0x7E, L=3: burst read when enabled, single read otherwise.
    resp_rand = 1'b1;
    addr_log.delete();
    do_cmd(1'b0, 1'b1, 6'h3E, 3, 8'h00);
    wait_idle();
`ifdef AVR_IO_BRIDGE_BURST_EN
    exp_addrs = '{6'h3E, 6'h3F, 6'h00, 6'h01};
`else
    exp_addrs = '{6'h3E};
`endif
    chk("burst_len", addr_log.size(), exp_addrs.size());
    for (int i = 0; i < exp_addrs.size() && i < addr_log.size(); i++)
      chk("burst_addr", addr_log[i], exp_addrs[i]);

    // Randomized traffic.
    gnt_rand = 1'b1;
    tx_rand  = 1'b1;
    max_gap  = 2;
    repeat (40) begin
      do_cmd($urandom_range(0, 1), $urandom_range(0, 1), 6'($urandom),
             $urandom_range(0, 5), 8'($urandom));
    end
    wait_idle();
    gnt_rand = 1'b0;
    tx_rand  = 1'b0;
    max_gap  = 0;
    @(posedge clk);
    #1;

    // Reset asserted during the XFER of a write.
    bus_gnt  = 1'b0;
    tx_ready = 1'b1;
    do_cmd(1'b1, 1'b0, 6'h21, 0, 8'h77);
    bus_gnt = 1'b1;
    @(posedge clk);
    #1 rst = 1'b1;
    exp_bus_q.delete();
    exp_tx_q.delete();
    s0 = strobe_cnt;
    @(negedge clk);
    chk("xrst_outputs", {rx_ready, tx_valid, bus_req, tx_data}, {1'b1, 1'b0, 1'b0, 8'h00});
    chk("xrst_strobes", {io_read === 1'b1, io_write === 1'b1}, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("xrst_no_strobe", strobe_cnt - s0, 0);
    chk("xrst_idle", {rx_ready, bus_req, tx_valid}, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
